// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
// Shared constants for the hazard controller: opcode and data-cache control
// encodings used by decode/execute, the controller FSM state encoding, the
// default data-cache watchdog limit, and helpers that classify which source
// registers an opcode reads.
package pipeline_hazard_ctrl_pkg;

  localparam int OpcodeSize        = 7;
  localparam int RegAddrSize       = 5;
  localparam int DataCacheCtrlSize = 2;

  // Opcodes of the instruction classes that read source registers.
  localparam logic [OpcodeSize-1:0] I_Imm    = 7'b0010011;
  localparam logic [OpcodeSize-1:0] I_Load   = 7'b0000011;
  localparam logic [OpcodeSize-1:0] R_Store  = 7'b0100011;
  localparam logic [OpcodeSize-1:0] R_RRop   = 7'b0110011;
  localparam logic [OpcodeSize-1:0] B_BRANCH = 7'b1100011;

  // Data-cache control encodings carried through DEC_ALU.
  localparam logic [DataCacheCtrlSize-1:0] DataCacheNOP   = 2'd0;
  localparam logic [DataCacheCtrlSize-1:0] DataCacheRead  = 2'd1;
  localparam logic [DataCacheCtrlSize-1:0] DataCacheWrite = 2'd2;

  localparam int DefaultMemTimeout = 64;

  typedef enum logic [1:0] {
    HazState_RUN      = 2'd0,
    HazState_MEM_WAIT = 2'd1,
    HazState_FLUSH    = 2'd2
  } haz_state_t;

  // True when the opcode consumes readAddr1.
  function automatic logic reads_rs1(input logic [OpcodeSize-1:0] op);
    case (op)
      I_Imm, I_Load, R_Store, R_RRop, B_BRANCH: reads_rs1 = 1'b1;
      default:                                  reads_rs1 = 1'b0;
    endcase
  endfunction

  // True when the opcode consumes readAddr2.
  function automatic logic reads_rs2(input logic [OpcodeSize-1:0] op);
    case (op)
      R_Store, R_RRop, B_BRANCH: reads_rs2 = 1'b1;
      default:                   reads_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect
// Purely combinational load-use hazard detector. Flags when the instruction
// in execute is a register-writing load whose destination (non-zero) is a
// source operand actually read by the instruction in decode.
// Ports:
//   id_opcode, id_rs1, id_rs2 : decode-stage opcode and source addresses
//   ex_dcache_ctrl            : data-cache control held in DEC_ALU
//   ex_reg_write              : register write enable held in DEC_ALU
//   ex_write_addr             : destination register held in DEC_ALU
//   hazard                    : load-use hazard present this cycle
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [OpcodeSize-1:0]        id_opcode,
  input  logic [RegAddrSize-1:0]       id_rs1,
  input  logic [RegAddrSize-1:0]       id_rs2,
  input  logic [DataCacheCtrlSize-1:0] ex_dcache_ctrl,
  input  logic                         ex_reg_write,
  input  logic [RegAddrSize-1:0]       ex_write_addr,
  output logic                         hazard
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real dependency, so a load targeting it cannot stall.
  assign ex_is_load = (ex_dcache_ctrl == DataCacheRead) && ex_reg_write &&
                      (ex_write_addr != 5'd0);
  assign rs1_hit    = reads_rs1(id_opcode) && (ex_write_addr == id_rs1);
  assign rs2_hit    = reads_rs2(id_opcode) && (ex_write_addr == id_rs2);
  assign hazard     = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Sequencing controller for the decode/execute datapath: drives stall, flush
// and bubble controls into PC, IF_ID and DEC_ALU for load-use hazards, taken
// branches and multi-cycle data-cache accesses, and watches the data cache
// for a stuck busy. Priority: rst > dcache_busy > ex_branch_taken > load-use.
// Build option: define HAZARD_PERF_CNT_EN to build the stall/flush counters;
// otherwise stall_cycles and flush_count are constant 0.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   id_opcode, id_rs1, id_rs2  : decode-stage instruction fields
//   ex_dcache_ctrl, ex_reg_write, ex_write_addr : DEC_ALU fields
//   ex_branch_taken            : branch in execute resolved taken
//   dcache_busy                : data cache still servicing execute access
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble : controls
//   mem_timeout_err            : sticky watchdog flag
//   stall_cycles, flush_count  : performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DefaultMemTimeout
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OpcodeSize-1:0]        id_opcode,
  input  logic [RegAddrSize-1:0]       id_rs1,
  input  logic [RegAddrSize-1:0]       id_rs2,
  input  logic [DataCacheCtrlSize-1:0] ex_dcache_ctrl,
  input  logic                         ex_reg_write,
  input  logic [RegAddrSize-1:0]       ex_write_addr,
  input  logic                         ex_branch_taken,
  input  logic                         dcache_busy,
  output logic                         pc_stall,
  output logic                         if_id_stall,
  output logic                         if_id_flush,
  output logic                         id_ex_stall,
  output logic                         id_ex_bubble,
  output logic                         mem_timeout_err,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  flush_count
);

  localparam int WdWidth = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WdWidth-1:0] WdMax = WdWidth'(MEM_TIMEOUT);

  haz_state_t state, state_next;
  logic load_use;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_bubble_c;
  logic [WdWidth-1:0] wd_cnt, wd_next;
  logic err_q;

  load_use_detect u_load_use_detect (
    .id_opcode      (id_opcode),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_dcache_ctrl (ex_dcache_ctrl),
    .ex_reg_write   (ex_reg_write),
    .ex_write_addr  (ex_write_addr),
    .hazard         (load_use)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= HazState_RUN;
    else     state <= state_next;
  end

  // Next state and control outputs. MEM_WAIT shares the RUN rules: while busy
  // it keeps stalling, and once busy drops the branch/load-use rules apply in
  // that same cycle.
  always_comb begin
    state_next     = state;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    case (state)
      HazState_RUN, HazState_MEM_WAIT: begin
        if (dcache_busy) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          id_ex_stall_c = 1'b1;
          state_next    = HazState_MEM_WAIT;
        end else if (ex_branch_taken) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          state_next     = HazState_FLUSH;
        end else if (load_use) begin
          // The bubble removes the load from execute, so no extra state.
          pc_stall_c     = 1'b1;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          state_next     = HazState_RUN;
        end else begin
          state_next     = HazState_RUN;
        end
      end
      HazState_FLUSH: begin
        // Kill the second wrong-path fetch; execute holds a bubble, so busy
        // is irrelevant here.
        if_id_flush_c = 1'b1;
        state_next    = HazState_RUN;
      end
      default: begin
        state_next = HazState_RUN;
      end
    endcase
  end

  assign pc_stall     = pc_stall_c     & ~rst;
  assign if_id_stall  = if_id_stall_c  & ~rst;
  assign if_id_flush  = if_id_flush_c  & ~rst;
  assign id_ex_stall  = id_ex_stall_c  & ~rst;
  assign id_ex_bubble = id_ex_bubble_c & ~rst;

  // Watchdog next count: clears whenever busy is low, counts busy cycles in
  // MEM_WAIT and saturates at the limit.
  always_comb begin
    wd_next = wd_cnt;
    if (!dcache_busy) begin
      wd_next = '0;
    end else if ((state == HazState_MEM_WAIT) && (wd_cnt < WdMax)) begin
      wd_next = wd_cnt + WdWidth'(1);
    end else begin
      wd_next = wd_cnt;
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= wd_next;
      err_q  <= err_q | (wd_next == WdMax);
    end
  end

  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Performance counters; they wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      stall_q <= stall_q + {31'd0, pc_stall};
      flush_q <= flush_q + {31'd0, if_id_flush};
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the decode/execute datapath. It sits beside the decoder and control unit and drives stall, flush and bubble controls into PC, IF_ID and DEC_ALU. It handles three cases: load-use hazards, taken branches, and multi-cycle data-cache accesses. It also runs a timeout watchdog on the data cache.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum cycles `dcache_busy` may stay high before `mem_timeout_err` sets.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_opcode  in  7  opcode of the instruction in decode (`OpcodeSize`)
- id_rs1  in  5  decode readAddr1 (`RegAddrSize`)
- id_rs2  in  5  decode readAddr2
- ex_dcache_ctrl  in  `DataCacheControlBus`  dataCacheControl held in DEC_ALU
- ex_reg_write  in  1  regWriteEnable held in DEC_ALU
- ex_write_addr  in  5  writeAddr held in DEC_ALU
- ex_branch_taken  in  1  branch in execute resolved taken
- dcache_busy  in  1  data cache still servicing the access in execute
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF_ID
- if_id_flush  out  1  load NOP into IF_ID
- id_ex_stall  out  1  hold DEC_ALU
- id_ex_bubble  out  1  load DEC_ALU with ALUopReset, RegWriteDeny and DataCacheNOP
- mem_timeout_err  out  1  sticky watchdog flag
- stall_cycles  out  32  performance counter (see Configuration)
- flush_count  out  32  performance counter (see Configuration)

## Operation
- The FSM has three states: RUN, MEM_WAIT and FLUSH. Reset places it in RUN.

Load-use detection (combinational, sub-module):
- The hazard condition is `ex_dcache_ctrl`==DataCacheRead AND `ex_reg_write` AND `ex_write_addr`!=0.
- It must also match a source register:
  - `ex_write_addr`==`id_rs1` for I_Imm, I_Load, R_Store, R_RRop and B_BRANCH;
  - or `ex_write_addr`==`id_rs2` for R_Store, R_RRop and B_BRANCH only.

Per-state output rules:
- RUN, with `dcache_busy`:
  - assert `pc_stall`, `if_id_stall` and `id_ex_stall`;
  - go to MEM_WAIT.
- RUN, else with `ex_branch_taken`:
  - assert `if_id_flush` and `id_ex_bubble`;
  - go to FLUSH.
- RUN, else with load-use:
  - assert `pc_stall`, `if_id_stall` and `id_ex_bubble`;
  - stay in RUN, because the bubble clears the hazard on the next cycle.
- MEM_WAIT:
  - hold all three stall outputs while `dcache_busy`;
  - when `dcache_busy` drops, evaluate the RUN rules in the same cycle, so a pending branch or load-use acts immediately, and take the corresponding next state.
- FLUSH:
  - assert `if_id_flush` for one cycle to kill the second wrong-path fetch;
  - return to RUN;
  - `dcache_busy` here is ignored because the execute stage holds a bubble.

Priority and watchdog:
- Priority order: rst > dcache_busy > ex_branch_taken > load-use.
- The watchdog counter clears on every cycle with `dcache_busy` low and increments while `dcache_busy` is high in MEM_WAIT.
- When the count reaches MEM_TIMEOUT, `mem_timeout_err` sets and stays set until rst. The FSM keeps waiting.

## Timing
- All control outputs are combinational from state and inputs, valid in the same cycle. No added latency.
- A load-use stall costs exactly 1 bubble cycle.
- A taken branch costs exactly 2 flushed slots: the detection cycle plus FLUSH.
- A memory wait of N busy cycles stalls N cycles.
- Reset values: state RUN; watchdog 0; `mem_timeout_err` 0; both counters 0.
- While `rst` is high, all stall, flush and bubble outputs are 0.
- Reset mid-MEM_WAIT or mid-FLUSH returns the FSM to RUN on the next edge.
- The watchdog counter saturates at MEM_TIMEOUT.

## Configuration
- With `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_stall` high;
  - `flush_count` increments on every cycle with `if_id_flush` high;
  - both are 32-bit and wrap to 0 after 0xFFFFFFFF.
- Without it, both outputs are constant 0 and no counter flops are built.

## Structure
- define.v receives:
  - the FSM state encodings (`HazState_RUN`, `HazState_MEM_WAIT`, `HazState_FLUSH`, 2 bits);
  - the default MEM_TIMEOUT.
- Existing opcode and DataCache constants are reused from define.v.
- Sub-module `load_use_detect` is purely combinational: opcode, rs1, rs2 and ex fields in, hazard flag out.

## Test plan
- Load-use:
  - stimulus: EX = LW x5 (DataCacheRead, regWrite, wa=5); ID = R_RRop with rs2=5;
  - response: `pc_stall`=`if_id_stall`=`id_ex_bubble`=1 for exactly 1 cycle.
- Load-use negatives:
  - same EX with wa=0 gives no stall;
  - ID = I_Imm with rs2 field =5 gives no stall.
- Taken branch:
  - stimulus: `ex_branch_taken`=1 in cycle t;
  - response: t has `if_id_flush`=`id_ex_bubble`=1; t+1 has `if_id_flush`=1 only; t+2 returns to RUN with all outputs 0.
- Memory wait:
  - stimulus: `dcache_busy` high for 5 cycles with a load-use pending;
  - response: 5 stall cycles, then a 1-cycle bubble in the cycle busy drops.
- Watchdog:
  - stimulus: MEM_TIMEOUT=8, `dcache_busy` held 20 cycles;
  - response: `mem_timeout_err` rises after 8 busy cycles in MEM_WAIT; it stays 1 after busy drops and clears only on rst.
- Reset and counters:
  - stimulus: rst asserted during FLUSH;
  - response: RUN next cycle, outputs 0.
  - With `HAZARD_PERF_CNT_EN`, after one branch plus one load-use: `flush_count`=2 and `stall_cycles`=1.
